cp0_reg: RTL and testbench

CP0_REG -- requirements
Module: cp0_reg

---
 rtl/cp0_pkg.sv | 34 +++
 rtl/cp0_reg_if.sv | 11 +
 rtl/cp0_timer.sv | 48 ++++
 rtl/cp0_reg.sv | 129 ++++++++++++
 tb/tb_cp0_reg.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field bit positions
// and the exception vector.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_INT     = 32'h1;
    localparam logic [31:0] EXC_ADEL    = 32'h4;
    localparam logic [31:0] EXC_ADES    = 32'h5;
    localparam logic [31:0] EXC_SYSCALL = 32'h8;
    localparam logic [31:0] EXC_BREAK   = 32'h9;
    localparam logic [31:0] EXC_RI      = 32'ha;
    localparam logic [31:0] EXC_OVF     = 32'hc;
    localparam logic [31:0] EXC_ERET    = 32'he;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_TI   = 30;

    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    function automatic logic is_addr_exc(input logic [31:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// MTC0/MFC0 access bus to the CP0 register file.
interface cp0_reg_if;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;

    modport master (output we, waddr, wdata, raddr, input rdata);
    modport slave  (input we, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second clock, TI raised on match
// and cleared by any write to Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        tick_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        ti_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_reg    <= 1'b0;
            count_reg   <= 32'd0;
            compare_reg <= 32'd0;
            ti_reg      <= 1'b0;
        end else begin
            tick_reg <= ~tick_reg;
            // A software write to Count replaces this cycle's increment.
            if (we && waddr == CP0_COUNT)
                count_reg <= wdata;
            else if (tick_reg)
                count_reg <= count_reg + 32'd1;

            if (we && waddr == CP0_COMPARE) begin
                compare_reg <= wdata;
                ti_reg      <= 1'b0;
            end else if (compare_reg != 32'd0 && count_reg == compare_reg) begin
                ti_reg <= 1'b1;
            end
        end
    end

    assign count   = count_reg;
    assign compare = compare_reg;
    assign ti      = ti_reg;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: exception entry/return, MTC0/MFC0 access and interrupt pending bits.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_reg
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exception_type,
    input  logic [31:0] pc,
    input  logic        in_delayslot,
    input  logic [31:0] bad_addr,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timer_int_o
);

    logic        exc;
    logic        eret;
    logic        wr;

    logic [7:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [5:0]  ip_hw_reg;
    logic [1:0]  ip_sw_reg;
    logic [4:0]  exccode_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_reg;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    assign exc  = (exception_type != 32'd0);
    assign eret = (exception_type == EXC_ERET);
    // Any exception, ERET included, swallows a same-cycle MTC0.
    assign wr   = we && !exc;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .we      (wr),
        .waddr   (waddr),
        .wdata   (wdata),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );
`else
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ti      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            im_reg       <= 8'd0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_hw_reg    <= 6'd0;
            ip_sw_reg    <= 2'd0;
            exccode_reg  <= 5'd0;
            epc_reg      <= 32'd0;
            badvaddr_reg <= 32'd0;
        end else begin
            ip_hw_reg <= {int_i[5] | ti, int_i[4:0]};
            if (exc) begin
                if (eret) begin
                    exl_reg <= 1'b0;
                end else begin
                    exl_reg     <= 1'b1;
                    exccode_reg <= (exception_type == EXC_INT) ? 5'd0 : exception_type[4:0];
                    // Nested exceptions keep the original return point.
                    if (!exl_reg) begin
                        bd_reg  <= in_delayslot;
                        epc_reg <= in_delayslot ? (pc - 32'd4) : pc;
                    end
                    if (is_addr_exc(exception_type))
                        badvaddr_reg <= bad_addr;
                end
            end else if (wr) begin
                case (waddr)
                    CP0_STATUS: begin
                        im_reg  <= wdata[15:8];
                        exl_reg <= wdata[STATUS_EXL];
                        ie_reg  <= wdata[STATUS_IE];
                    end
                    CP0_CAUSE: ip_sw_reg <= wdata[9:8];
                    CP0_EPC:   epc_reg   <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign status_o = {9'd0, 1'b1, 6'd0, im_reg, 6'd0, exl_reg, ie_reg};
    assign cause_o  = {bd_reg, ti, 14'd0, ip_hw_reg, ip_sw_reg, 1'b0, exccode_reg, 2'b00};
    assign epc_o    = epc_reg;

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            CP0_BADVADDR: rdata = badvaddr_reg;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status_o;
            CP0_CAUSE:    rdata = cause_o;
            CP0_EPC:      rdata = epc_reg;
            default:      rdata = 32'd0;
        endcase
    end

    assign flush       = exc;
    assign new_pc      = eret ? epc_reg : EXC_VECTOR;
    assign timer_int_o = ti;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed self-checking bench for cp0_reg; timer checks follow CP0_TIMER_EN.
module tb_cp0_reg;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exception_type;
    logic [31:0] pc;
    logic        in_delayslot;
    logic [31:0] bad_addr;
    logic [5:0]  int_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        flush;
    logic [31:0] new_pc;
    logic        timer_int_o;

    int total = 0;
    int bad   = 0;

    cp0_reg_if bus ();

    cp0_reg dut (
        .clk            (clk),
        .rst            (rst),
        .exception_type (exception_type),
        .pc             (pc),
        .in_delayslot   (in_delayslot),
        .bad_addr       (bad_addr),
        .we             (bus.we),
        .waddr          (bus.waddr),
        .wdata          (bus.wdata),
        .raddr          (bus.raddr),
        .rdata          (bus.rdata),
        .int_i          (int_i),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .flush          (flush),
        .new_pc         (new_pc),
        .timer_int_o    (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic mfc0(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.raddr = a;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic raise(input logic [31:0] code, input logic [31:0] p, input logic ds,
                         input logic [31:0] ba);
        exception_type = code; pc = p; in_delayslot = ds; bad_addr = ba;
        tick();
        exception_type = 32'd0;
    endtask

    logic [4:0]  rd_addr [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    logic [31:0] rd_exp  [8] = '{32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0, 32'd0, 32'd0};

    initial begin
        rst = 1'b0; exception_type = 32'd0; pc = 32'd0; in_delayslot = 1'b0;
        bad_addr = 32'd0; int_i = 6'd0;
        bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0; bus.raddr = 5'd0;
        tick(); tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            mfc0($sformatf("reset_rd%0d", rd_addr[i]), rd_addr[i], rd_exp[i]);
        check("reset_flush", {31'd0, flush}, 32'd0);

        // Overflow in a delay slot
        exception_type = EXC_OVF; pc = 32'h8000_0100; in_delayslot = 1'b1;
        #1;
        check("ovf_flush", {31'd0, flush}, 32'd1);
        check("ovf_new_pc", new_pc, 32'hBFC0_0380);
        tick();
        exception_type = 32'd0;
        check("ovf_epc", epc_o, 32'h8000_00FC);
        check("ovf_cause", cause_o, 32'h8000_0030);
        check("ovf_status", status_o, 32'h0040_0002);

        // Nested syscall: EPC and BD kept, ExcCode updated, BadVAddr untouched
        raise(EXC_SYSCALL, 32'h8000_0200, 1'b0, 32'h1234_5678);
        check("nest_epc", epc_o, 32'h8000_00FC);
        check("nest_cause", cause_o, 32'h8000_0020);
        mfc0("nest_badvaddr", CP0_BADVADDR, 32'd0);

        raise(EXC_ADEL, 32'h8000_0300, 1'b0, 32'h0000_0003);
        mfc0("adel_badvaddr", CP0_BADVADDR, 32'h0000_0003);
        check("adel_cause", cause_o, 32'h8000_0010);

        exception_type = EXC_ERET;
        #1;
        check("eret_new_pc", new_pc, 32'h8000_00FC);
        check("eret_flush", {31'd0, flush}, 32'd1);
        tick();
        exception_type = 32'd0;
        check("eret_status", status_o, 32'h0040_0000);

        // Exception beats a same-cycle MTC0 to EPC
        bus.we = 1'b1; bus.waddr = CP0_EPC; bus.wdata = 32'h1234_5678;
        raise(EXC_SYSCALL, 32'h8000_0400, 1'b0, 32'd0);
        bus.we = 1'b0;
        check("prio_epc", epc_o, 32'h8000_0400);
        check("prio_cause", cause_o, 32'h0000_0020);
        raise(EXC_ERET, 32'd0, 1'b0, 32'd0);

        // Writable-field masks
        mtc0(CP0_STATUS, 32'hFFFF_FFFF);
        check("wr_status", status_o, 32'h0040_FF03);
        mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
        check("wr_cause", cause_o, 32'h0000_0320);
        mtc0(CP0_EPC, 32'hDEAD_BEEF);
        mfc0("wr_epc", CP0_EPC, 32'hDEAD_BEEF);

        // No bypass of a write in flight
        bus.we = 1'b1; bus.waddr = CP0_EPC; bus.wdata = 32'h0000_1111;
        mfc0("nobypass_epc", CP0_EPC, 32'hDEAD_BEEF);
        tick();
        bus.we = 1'b0;
        mfc0("after_wr_epc", CP0_EPC, 32'h0000_1111);

        // INT maps to ExcCode 0
        mtc0(CP0_STATUS, 32'd0);
        raise(EXC_INT, 32'h8000_0500, 1'b0, 32'd0);
        check("int_cause", cause_o, 32'h0000_0300);
        check("int_epc", epc_o, 32'h8000_0500);
        raise(EXC_ERET, 32'd0, 1'b0, 32'd0);

        int_i = 6'b100101;
        tick();
        check("hw_ip", cause_o, 32'h0000_9700);
        int_i = 6'd0;
        tick();

        // Reset wins over a same-cycle exception
        rst = 1'b0;
        raise(EXC_OVF, 32'h8000_0600, 1'b1, 32'd0);
        rst = 1'b1;
        check("rst_prio_epc", epc_o, 32'd0);
        check("rst_prio_status", status_o, 32'h0040_0000);
        check("rst_prio_cause", cause_o, 32'd0);

`ifdef CP0_TIMER_EN
        mtc0(CP0_COUNT, 32'h0000_0100);
        mfc0("tmr_count_wr", CP0_COUNT, 32'h0000_0100);
        mtc0(CP0_COMPARE, 32'd10);
        mtc0(CP0_COUNT, 32'd0);
        mfc0("tmr_compare", CP0_COMPARE, 32'd10);
        begin
            int n = 0;
            while (!timer_int_o && n < 60) begin
                tick();
                n++;
            end
            check("tmr_ti_set", {31'd0, timer_int_o}, 32'd1);
            check("tmr_cause_ti", {31'd0, cause_o[CAUSE_TI]}, 32'd1);
        end
        mtc0(CP0_COMPARE, 32'd1000);
        check("tmr_ti_clr", {31'd0, timer_int_o}, 32'd0);
`else
        mtc0(CP0_COMPARE, 32'd10);
        mtc0(CP0_COUNT, 32'd5);
        mfc0("notmr_compare", CP0_COMPARE, 32'd0);
        mfc0("notmr_count", CP0_COUNT, 32'd0);
        repeat (30) tick();
        check("notmr_ti", {31'd0, timer_int_o}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
